half_adder: RTL and testbench

Single-bit half adder with a combinational result path and a registered, valid-qualified result path, plus saturating event counters for observability. It forms sum = a XOR b and carry = a AND b for two 1-bit operands. It sits as a leaf arithmetic cell: the combinational outputs feed ripple/compressor logic directly, and the registered outputs and counters feed pipelined datapaths and debug status.

---
 rtl/half_adder.sv | 92 +++++++++
 tb/tb_half_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Single-bit half adder with a combinational result, a registered valid-qualified
// result, and saturating operation/carry event counters.
module half_adder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    input  logic             clr,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] carry_count
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             sum_d;
    logic             carry_d;
    logic             sum_r_q;
    logic             carry_r_q;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] op_cnt_d;
    logic [CNT_W-1:0] op_cnt_q;
    logic [CNT_W-1:0] carry_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;

    // Pure combinational half-add, independent of clock, reset and valid.
    always_comb begin
        sum   = a ^ b;
        carry = a & b;
    end

    // Result register captures on accept and holds otherwise; valid tracks accept.
    always_comb begin
        sum_d   = sum_r_q;
        carry_d = carry_r_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
        end
    end

    // Counters: clear wins over increment; each stops at all-ones instead of wrapping.
    always_comb begin
        op_cnt_d    = op_cnt_q;
        carry_cnt_d = carry_cnt_q;
        if (clr) begin
            op_cnt_d    = '0;
            carry_cnt_d = '0;
        end else if (in_valid) begin
            if (op_cnt_q != CntMax) begin
                op_cnt_d = op_cnt_q + CntOne;
            end
            if (carry && (carry_cnt_q != CntMax)) begin
                carry_cnt_d = carry_cnt_q + CntOne;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_q     <= 1'b0;
            carry_r_q   <= 1'b0;
            valid_q     <= 1'b0;
            op_cnt_q    <= '0;
            carry_cnt_q <= '0;
        end else begin
            sum_r_q     <= sum_d;
            carry_r_q   <= carry_d;
            valid_q     <= valid_d;
            op_cnt_q    <= op_cnt_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign sum_q       = sum_r_q;
    assign carry_q     = carry_r_q;
    assign out_valid   = valid_q;
    assign op_count    = op_cnt_q;
    assign carry_count = carry_cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: directed scenarios plus randomized traffic,
// checked against an arithmetic reference model. Two instances (16-bit and 4-bit
// counters) share the same stimulus.
module tb_half_adder;

    logic        clk;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        in_valid;
    logic        clr;

    logic        sum16, carry16, sum_q16, carry_q16, out_valid16;
    logic [15:0] op16, car16;
    logic        sum4, carry4, sum_q4, carry_q4, out_valid4;
    logic [3:0]  op4, car4;

    int unsigned checks;
    int unsigned failures;

    // Reference model state
    int unsigned m_sum_q, m_carry_q, m_valid;
    int unsigned m_op16, m_car16, m_op4, m_car4;

    half_adder #(.CNT_W(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .clr        (clr),
        .sum        (sum16),
        .carry      (carry16),
        .sum_q      (sum_q16),
        .carry_q    (carry_q16),
        .out_valid  (out_valid16),
        .op_count   (op16),
        .carry_count(car16)
    );

    half_adder #(.CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .clr        (clr),
        .sum        (sum4),
        .carry      (carry4),
        .sum_q      (sum_q4),
        .carry_q    (carry_q4),
        .out_valid  (out_valid4),
        .op_count   (op4),
        .carry_count(car4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sum_q = 0; m_carry_q = 0; m_valid = 0;
        m_op16 = 0; m_car16 = 0; m_op4 = 0; m_car4 = 0;
    endtask

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Model of one clock edge: the 2-bit sum a+b supplies carry and sum.
    task automatic model_edge(input logic ia, input logic ib, input logic iv, input logic ic);
        int unsigned total;
        total = int'(ia) + int'(ib);
        if (iv) begin
            m_sum_q   = total % 2;
            m_carry_q = total / 2;
            m_valid   = 1;
        end else begin
            m_valid = 0;
        end
        if (ic) begin
            m_op16 = 0; m_car16 = 0; m_op4 = 0; m_car4 = 0;
        end else if (iv) begin
            m_op16 = sat_inc(m_op16, 65535);
            m_op4  = sat_inc(m_op4, 15);
            if (total == 2) begin
                m_car16 = sat_inc(m_car16, 65535);
                m_car4  = sat_inc(m_car4, 15);
            end
        end
    endtask

    task automatic check_comb(input string tag);
        int unsigned total;
        total = int'(a) + int'(b);
        check({tag, ".sum16"},   32'(sum16),   total % 2);
        check({tag, ".carry16"}, 32'(carry16), total / 2);
        check({tag, ".sum4"},    32'(sum4),    total % 2);
        check({tag, ".carry4"},  32'(carry4),  total / 2);
        check({tag, ".exclusive"}, 32'(sum16 & carry16), 0);
    endtask

    task automatic check_all(input string tag);
        check_comb(tag);
        check({tag, ".sum_q16"},   32'(sum_q16),     m_sum_q);
        check({tag, ".carry_q16"}, 32'(carry_q16),   m_carry_q);
        check({tag, ".valid16"},   32'(out_valid16), m_valid);
        check({tag, ".op16"},      32'(op16),        m_op16);
        check({tag, ".car16"},     32'(car16),       m_car16);
        check({tag, ".sum_q4"},    32'(sum_q4),      m_sum_q);
        check({tag, ".carry_q4"},  32'(carry_q4),    m_carry_q);
        check({tag, ".valid4"},    32'(out_valid4),  m_valid);
        check({tag, ".op4"},       32'(op4),         m_op4);
        check({tag, ".car4"},      32'(car4),        m_car4);
    endtask

    // Called at a falling edge: drive, take one rising edge, check, return at next falling edge.
    task automatic step(input string tag, input logic ia, input logic ib,
                        input logic iv, input logic ic);
        a = ia; b = ib; in_valid = iv; clr = ic;
        #1;
        check_comb({tag, ".pre"});
        @(posedge clk);
        model_edge(ia, ib, iv, ic);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] ab;
        checks = 0;
        failures = 0;
        model_reset();
        rst_n = 1'b0; a = 1'b0; b = 1'b0; in_valid = 1'b0; clr = 1'b0;

        // Truth table at 5 ns spacing, clock-independent
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a = ab[1]; b = ab[0];
            #1;
            check_comb("tt");
            #4;
        end
        #30;
        check("tt_hold.sum",   32'(sum16),   0);
        check("tt_hold.carry", 32'(carry16), 1);
        check_all("reset_state");

        @(negedge clk);
        rst_n = 1'b1;

        // Registered path
        step("reg_acc", 1'b1, 1'b1, 1'b1, 1'b0);
        check("reg_acc.sum_q",   32'(sum_q16),     0);
        check("reg_acc.carry_q", 32'(carry_q16),   1);
        check("reg_acc.valid",   32'(out_valid16), 1);
        step("reg_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reg_idle.valid",   32'(out_valid16), 0);
        check("reg_idle.carry_q", 32'(carry_q16),   1);

        // Counters over 8 pairs cycling 00,01,10,11
        step("clr0", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            ab = 2'(i);
            step("cnt8", ab[1], ab[0], 1'b1, 1'b0);
        end
        check("cnt8.op16",  32'(op16),  8);
        check("cnt8.car16", 32'(car16), 2);

        // clr beats a same-edge increment
        step("clr_pri", 1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_pri.op16",  32'(op16),        0);
        check("clr_pri.car16", 32'(car16),       0);
        check("clr_pri.valid", 32'(out_valid16), 1);

        // Saturation of the 4-bit instance
        for (int i = 0; i < 20; i++) step("sat", 1'b1, 1'b1, 1'b1, 1'b0);
        check("sat.op4",  32'(op4),  15);
        check("sat.car4", 32'(car4), 15);
        check("sat.op16", 32'(op16), 20);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom), 1'($urandom), ($urandom_range(3) != 0),
                 ($urandom_range(31) == 0));
        end

        // Async reset mid-stream, checked before the next rising edge
        step("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
        step("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("post_rst", 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
